// File: rtl/fpu_result_tx.sv
// Serialises a 32-bit FPU result over a UART line as four 8N1 bytes, MSB byte first.
// The result is captured once at start acceptance so later input changes cannot corrupt a frame.
module fpu_result_tx #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int NUM_BYTES    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] result,
  output logic        busy,
  output logic        done,
  output logic        tx,
  output logic [1:0]  dbg_state_o
);

  localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [1:0]    BYTE_LAST = 2'(NUM_BYTES - 1);

  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [31:0]   shadow_q, shadow_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;

  logic [7:0] cur_byte;
  logic [2:0] bit_nxt;
  logic       bit_end;

  always_comb begin
    case (byte_q)
      2'd0:    cur_byte = shadow_q[31:24];
      2'd1:    cur_byte = shadow_q[23:16];
      2'd2:    cur_byte = shadow_q[15:8];
      default: cur_byte = shadow_q[7:0];
    endcase
  end

  assign bit_nxt = bit_q + 3'd1;
  assign bit_end = (baud_q == BAUD_LAST);

  // tx_d is the line level for the next cycle, so tx changes on the same edge as the state.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    shadow_d = shadow_q;
    tx_d     = tx_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (start) begin
          shadow_d = result;
          byte_d   = 2'd0;
          bit_d    = 3'd0;
          tx_d     = 1'b0;
          state_d  = START_BIT;
        end
      end
      START_BIT: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = cur_byte[0];
          state_d = DATA_BITS;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      DATA_BITS: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP_BIT;
          end else begin
            bit_d = bit_nxt;
            tx_d  = cur_byte[bit_nxt];
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      STOP_BIT: begin
        if (bit_end) begin
          baud_d = '0;
          if (byte_q == BYTE_LAST) begin
            tx_d    = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            byte_d  = byte_q + 2'd1;
            tx_d    = 1'b0;
            state_d = START_BIT;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      shadow_q <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      shadow_q <= shadow_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign tx          = tx_q;
  assign dbg_state_o = state_q;

endmodule
